// File: rtl/can_stuff.sv
// Transmit-side CAN bit stuffer: inserts a complementary bit after MAX_RUN equal
// bits while stuffing is enabled, advancing one bit per Tx_Point strobe.
module can_stuff #(
   parameter int MAX_RUN = 5,
   parameter int CNT_W   = 5
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             Tx_Point,
   input  logic             Stuff_Enable,
   input  logic             Bit_Valid,
   input  logic             Bit_In,
   output logic             Bit_Ready,
   output logic             Bit_Output,
   output logic             Stuff_Bit,
   output logic [CNT_W-1:0] Stuff_Count,
   output logic             Underrun
);

   localparam int RUN_W = $clog2(MAX_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);

   logic [RUN_W-1:0] run, run_n, run_base;
   logic             last_level, last_level_n;
   logic             en_q, en_q_n;
   logic             out_n, stuff_n, underrun_n, underrun_base, level;
   logic [CNT_W-1:0] count_n, count_base;
   logic             stuff_pending, rise;

   assign stuff_pending = (run == RUN_MAX);
   assign Bit_Ready     = Tx_Point & ~stuff_pending;

   always_comb begin
      run_n         = run;
      last_level_n  = last_level;
      en_q_n        = en_q;
      out_n         = Bit_Output;
      stuff_n       = Stuff_Bit;
      count_n       = Stuff_Count;
      underrun_n    = Underrun;
      rise          = 1'b0;
      run_base      = run;
      count_base    = Stuff_Count;
      underrun_base = Underrun;
      level         = 1'b1;
      if (Tx_Point) begin
         en_q_n = Stuff_Enable;
         // A new stuff region starts clean before its first bit is handled
         rise = Stuff_Enable & ~en_q;
         if (rise) begin
            run_base      = '0;
            count_base    = '0;
            underrun_base = 1'b0;
         end
         count_n    = count_base;
         underrun_n = underrun_base;
         if (stuff_pending) begin
            out_n        = ~last_level;
            stuff_n      = 1'b1;
            run_n        = RUN_W'(1);
            last_level_n = ~last_level;
            count_n      = (count_base == {CNT_W{1'b1}}) ? count_base : count_base + 1'b1;
         end else if (Stuff_Enable) begin
            // A missing bit still goes out as recessive and counts in the run
            level        = Bit_Valid ? Bit_In : 1'b1;
            out_n        = level;
            stuff_n      = 1'b0;
            run_n        = (level == last_level) ? run_base + 1'b1 : RUN_W'(1);
            last_level_n = level;
            if (!Bit_Valid) underrun_n = 1'b1;
         end else begin
            level        = Bit_Valid ? Bit_In : 1'b1;
            out_n        = level;
            stuff_n      = 1'b0;
            run_n        = '0;
            last_level_n = level;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         run         <= '0;
         last_level  <= 1'b1;
         en_q        <= 1'b0;
         Bit_Output  <= 1'b1;
         Stuff_Bit   <= 1'b0;
         Stuff_Count <= '0;
         Underrun    <= 1'b0;
      end else begin
         run         <= run_n;
         last_level  <= last_level_n;
         en_q        <= en_q_n;
         Bit_Output  <= out_n;
         Stuff_Bit   <= stuff_n;
         Stuff_Count <= count_n;
         Underrun    <= underrun_n;
      end
   end

endmodule

// File: tb/tb_can_stuff.sv
// Directed bench for can_stuff: stuffing, underrun, enable edges and reset.
module tb_can_stuff;

   logic       Clock = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Tx_Point = 1'b0;
   logic       Stuff_Enable = 1'b0;
   logic       Bit_Valid = 1'b0;
   logic       Bit_In = 1'b0;
   logic       Bit_Ready, Bit_Output, Stuff_Bit, Underrun;
   logic [4:0] Stuff_Count;

   int n_chk  = 0;
   int n_fail = 0;

   can_stuff #(.MAX_RUN(5), .CNT_W(5)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .Tx_Point(Tx_Point),
      .Stuff_Enable(Stuff_Enable), .Bit_Valid(Bit_Valid), .Bit_In(Bit_In),
      .Bit_Ready(Bit_Ready), .Bit_Output(Bit_Output), .Stuff_Bit(Stuff_Bit),
      .Stuff_Count(Stuff_Count), .Underrun(Underrun)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One bit time: present inputs, check Bit_Ready before the edge, outputs after it
   task automatic step(input string tag, input logic en, input logic v, input logic b,
                       input logic exp_rdy, input logic exp_out, input logic exp_stf);
      @(negedge Clock);
      Stuff_Enable = en; Bit_Valid = v; Bit_In = b; Tx_Point = 1'b1;
      #1;
      chk({tag, ".rdy"}, 8'(Bit_Ready), 8'(exp_rdy));
      @(posedge Clock);
      #1;
      Tx_Point = 1'b0; Bit_Valid = 1'b0;
      chk({tag, ".out"}, 8'(Bit_Output), 8'(exp_out));
      chk({tag, ".stf"}, 8'(Stuff_Bit), 8'(exp_stf));
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge Clock);
      #1;
      chk("rst.out", 8'(Bit_Output), 8'd1);
      chk("rst.stf", 8'(Stuff_Bit), 8'd0);
      chk("rst.cnt", 8'(Stuff_Count), 8'd0);
      chk("rst.und", 8'(Underrun), 8'd0);
      @(negedge Clock);
      Reset_n = 1'b1;
      repeat (3) @(posedge Clock);
      #1;
      chk("rst.noemit", 8'(Bit_Output), 8'd1);
      chk("rst.rdy_idle", 8'(Bit_Ready), 8'd0);

      // T2: five 0s then 1 -> stuff 1 inserted
      for (int i = 0; i < 5; i++) step("t2.d0", 1, 1, 0, 1, 0, 0);
      step("t2.stuff", 1, 1, 1, 0, 1, 1);
      chk("t2.cnt1", 8'(Stuff_Count), 8'd1);
      step("t2.d1", 1, 1, 1, 1, 1, 0);
      chk("t2.run", 8'(dut.run), 8'd2);
      chk("t2.cnt", 8'(Stuff_Count), 8'd1);

      // T3: five 1s, five 0s -> two stuff bits
      step("t3.idle", 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 5; i++) step("t3.d1", 1, 1, 1, 1, 1, 0);
      step("t3.s0", 1, 1, 0, 0, 0, 1);
      chk("t3.cnt1", 8'(Stuff_Count), 8'd1);
      for (int i = 0; i < 4; i++) step("t3.d0", 1, 1, 0, 1, 0, 0);
      step("t3.s1", 1, 1, 0, 0, 1, 1);
      step("t3.d0last", 1, 1, 0, 1, 0, 0);
      chk("t3.cnt", 8'(Stuff_Count), 8'd2);

      // T4: alternating bits pass through unchanged; rising edge clears count
      step("t4.idle", 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 10; i++) begin
         logic b;
         b = (i % 2 == 0);
         step("t4.alt", 1, 1, b, 1, b, 0);
      end
      chk("t4.cnt", 8'(Stuff_Count), 8'd0);

      // T5: pending stuff survives the falling edge of enable, then no stuffing
      step("t5.idle", 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 5; i++) step("t5.d0", 1, 1, 0, 1, 0, 0);
      step("t5.stuff", 0, 1, 0, 0, 1, 1);
      for (int i = 0; i < 6; i++) step("t5.post", 0, 1, 0, 1, 0, 0);
      chk("t5.cnt", 8'(Stuff_Count), 8'd1);

      // T6: underrun is sticky and counts as recessive in the run
      step("t6.d1", 1, 1, 1, 1, 1, 0);
      step("t6.miss", 1, 0, 0, 1, 1, 0);
      chk("t6.und", 8'(Underrun), 8'd1);
      for (int i = 0; i < 3; i++) step("t6.d1b", 1, 1, 1, 1, 1, 0);
      chk("t6.run", 8'(dut.run), 8'd5);
      // No strobe: nothing moves even with valid data offered
      @(negedge Clock);
      Bit_Valid = 1'b1; Bit_In = 1'b0;
      #1;
      chk("t6.hold.rdy", 8'(Bit_Ready), 8'd0);
      repeat (3) @(posedge Clock);
      #1;
      chk("t6.hold.out", 8'(Bit_Output), 8'd1);
      chk("t6.hold.run", 8'(dut.run), 8'd5);
      Bit_Valid = 1'b0;
      step("t6.s0", 1, 1, 0, 0, 0, 1);
      chk("t6.cnt1", 8'(Stuff_Count), 8'd1);
      step("t6.off", 0, 0, 0, 1, 1, 0);
      chk("t6.und_held", 8'(Underrun), 8'd1);
      chk("t6.cnt_held", 8'(Stuff_Count), 8'd1);
      step("t6.rise", 1, 1, 0, 1, 0, 0);
      chk("t6.und_clr", 8'(Underrun), 8'd0);
      chk("t6.cnt_clr", 8'(Stuff_Count), 8'd0);

      // T1: reset mid-stream forces recessive at once
      step("t1.d0", 1, 1, 0, 1, 0, 0);
      step("t1.d0b", 1, 1, 0, 1, 0, 0);
      @(negedge Clock);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("t1.out", 8'(Bit_Output), 8'd1);
      chk("t1.stf", 8'(Stuff_Bit), 8'd0);
      chk("t1.cnt", 8'(Stuff_Count), 8'd0);
      chk("t1.und", 8'(Underrun), 8'd0);
      chk("t1.run", 8'(dut.run), 8'd0);
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Reset_n = 1'b1;
      repeat (3) @(posedge Clock);
      #1;
      chk("t1.noemit", 8'(Bit_Output), 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
